// File: rtl/alu_slice_controller_if.sv
// Issue/decode bus between the microsequencer and the Am2901-style slice controller.
// Optional forwarding outputs are present when HAZARD_FWD_EN is defined.
interface alu_slice_controller_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned REGS  = 16
);
  localparam int unsigned AW = $clog2(REGS);

  logic              instr_valid;
  logic              instr_ready;
  logic [8:0]        i;
  logic [AW-1:0]     a;
  logic [AW-1:0]     b;
  logic [WIDTH-1:0]  f;
  logic [WIDTH-1:0]  c;
  logic [REGS-1:0]   select_a_hi;
  logic [REGS-1:0]   select_b_hi;
  logic              shift_left;
  logic              shift_right;
  logic              y_sel_a;
  logic              reg_wr;
  logic [REGS-1:0]   select_wr_hi;
  logic [1:0]        select_q_reg;
  logic              flag_z;
  logic              flag_n;
  logic              flag_c;
  logic              flag_v;
`ifdef HAZARD_FWD_EN
  logic              fwd_a;
  logic              fwd_b;
  logic              fwd_q;

  modport master (
    output instr_valid, i, a, b, f, c,
    input  instr_ready, select_a_hi, select_b_hi, shift_left, shift_right, y_sel_a,
    input  reg_wr, select_wr_hi, select_q_reg, flag_z, flag_n, flag_c, flag_v,
    input  fwd_a, fwd_b, fwd_q
  );
  modport slave (
    input  instr_valid, i, a, b, f, c,
    output instr_ready, select_a_hi, select_b_hi, shift_left, shift_right, y_sel_a,
    output reg_wr, select_wr_hi, select_q_reg, flag_z, flag_n, flag_c, flag_v,
    output fwd_a, fwd_b, fwd_q
  );
`else
  modport master (
    output instr_valid, i, a, b, f, c,
    input  instr_ready, select_a_hi, select_b_hi, shift_left, shift_right, y_sel_a,
    input  reg_wr, select_wr_hi, select_q_reg, flag_z, flag_n, flag_c, flag_v
  );
  modport slave (
    input  instr_valid, i, a, b, f, c,
    output instr_ready, select_a_hi, select_b_hi, shift_left, shift_right, y_sel_a,
    output reg_wr, select_wr_hi, select_q_reg, flag_z, flag_n, flag_c, flag_v
  );
`endif
endinterface

// File: rtl/alu_slice_controller.sv
// Two-stage (EX/WB) Am2901 microinstruction decoder for a WIDTH-bit, REGS-entry slice array.
// Define HAZARD_FWD_EN to replace the RAW stall with forwarding indications.
module alu_slice_controller #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned REGS  = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  alu_slice_controller_if.slave bus
);
  localparam int unsigned AW = $clog2(REGS);
  typedef logic [AW-1:0] addr_t;

  function automatic logic [REGS-1:0] onehot(input addr_t idx);
    logic [REGS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // QREG and NOP are the only destinations that leave the register file alone.
  function automatic logic dest_writes_reg(input logic [2:0] dest);
    return (dest != 3'b000) && (dest != 3'b001);
  endfunction

  function automatic logic [1:0] q_ctrl(input logic [2:0] dest);
    logic [1:0] q;
    unique case (dest)
      3'b000:  q = 2'd2;
      3'b100:  q = 2'd1;
      3'b110:  q = 2'd3;
      default: q = 2'd0;
    endcase
    return q;
  endfunction

  function automatic logic src_uses_q(input logic [2:0] src);
    return (src == 3'b000) || (src == 3'b010) || (src == 3'b110);
  endfunction

  logic        ex_valid_q;
  logic [8:0]  ex_i_q;
  addr_t       ex_a_q;
  addr_t       ex_b_q;
  logic        wb_valid_q;
  logic        wb_wr_q;
  addr_t       wb_b_q;
  logic [1:0]  wb_q_q;
  logic        flag_z_q, flag_n_q, flag_c_q, flag_v_q;

  logic        ready;
  logic        accept;
  logic        reg_wr_int;
  logic [2:0]  ex_dest;

  assign ex_dest = ex_i_q[8:6];

`ifdef HAZARD_FWD_EN
  assign ready = 1'b1;
`else
  logic ex_wr;
  logic ex_wq;
  logic hazard;

  assign ex_wr  = ex_valid_q & dest_writes_reg(ex_dest);
  assign ex_wq  = ex_valid_q & (q_ctrl(ex_dest) != 2'd0);
  // A stalled instruction sees an empty EX next cycle, so the stall never exceeds one cycle.
  assign hazard = bus.instr_valid & ex_valid_q &
                  ((ex_wr & ((bus.a == ex_b_q) | (bus.b == ex_b_q))) |
                   (ex_wq & src_uses_q(bus.i[2:0])));
  assign ready  = ~hazard;
`endif

  assign accept     = bus.instr_valid & ready;
  assign reg_wr_int = wb_valid_q & wb_wr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_i_q     <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
    end else begin
      ex_valid_q <= accept;
      if (accept) begin
        ex_i_q <= bus.i;
        ex_a_q <= bus.a;
        ex_b_q <= bus.b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_wr_q    <= 1'b0;
      wb_b_q     <= '0;
      wb_q_q     <= 2'd0;
    end else begin
      wb_valid_q <= ex_valid_q;
      wb_wr_q    <= dest_writes_reg(ex_dest);
      wb_b_q     <= ex_b_q;
      wb_q_q     <= q_ctrl(ex_dest);
    end
  end

  // Flags reflect the most recent real EX result; bubbles leave them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
      flag_c_q <= 1'b0;
      flag_v_q <= 1'b0;
    end else if (ex_valid_q) begin
      flag_z_q <= (bus.f == '0);
      flag_n_q <= bus.f[WIDTH-1];
      flag_c_q <= bus.c[WIDTH-1];
      flag_v_q <= bus.c[WIDTH-1] ^ bus.c[WIDTH-2];
    end
  end

  always_comb begin
    bus.instr_ready  = ready;
    bus.select_a_hi  = ex_valid_q ? onehot(ex_a_q) : onehot('0);
    bus.select_b_hi  = ex_valid_q ? onehot(ex_b_q) : onehot('0);
    bus.shift_left   = ex_valid_q & (ex_dest[2:1] == 2'b11);
    bus.shift_right  = ex_valid_q & (ex_dest[2:1] == 2'b10);
    bus.y_sel_a      = ex_valid_q & (ex_dest == 3'b010);
    bus.reg_wr       = reg_wr_int;
    bus.select_wr_hi = reg_wr_int ? onehot(wb_b_q) : '0;
    bus.select_q_reg = wb_valid_q ? wb_q_q : 2'd0;
    bus.flag_z       = flag_z_q;
    bus.flag_n       = flag_n_q;
    bus.flag_c       = flag_c_q;
    bus.flag_v       = flag_v_q;
  end

`ifdef HAZARD_FWD_EN
  always_comb begin
    bus.fwd_a = ex_valid_q & reg_wr_int & (ex_a_q == wb_b_q);
    bus.fwd_b = ex_valid_q & reg_wr_int & (ex_b_q == wb_b_q);
    bus.fwd_q = ex_valid_q & wb_valid_q & (wb_q_q != 2'd0) & src_uses_q(ex_i_q[2:0]);
  end
`endif

  // The ALU function field and low carry bits are consumed by the slices, not here.
  logic unused_bits;
  assign unused_bits = ^{ex_i_q[5:3], bus.c[WIDTH-3:0]};

endmodule

// File: doc/alu_slice_controller.md
Name: alu_slice_controller

Overview:
Parametrised, pipelined successor to the single-slice Am2901 controller: decodes the 9-bit Am2901 microinstruction for a WIDTH-bit datapath (WIDTH/4 slices) with a REGS-entry register file. Two stages: EX drives the read selects and shifter enables; WB issues the register-file and Q writes and latches the status flags. Detects read-after-write hazards with a valid/ready issue handshake, and stalls or forwards.

Parameters:
WIDTH, 4, datapath width in bits; multiple of 4, minimum 4
REGS, 16, register-file depth; power of 2, minimum 2
AW, $clog2(REGS), register address width (derived; do not override)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
instr_valid  input  1  microinstruction offered
instr_ready  output  1  controller accepts the instruction this cycle
i  input  9  Am2901 microinstruction: [8:6] destination, [5:3] function, [2:0] source
a  input  AW  A read address
b  input  AW  B read address, also the write address
f  input  WIDTH  ALU result for the EX instruction
c  input  WIDTH  per-bit carry out of the ALU
select_a_hi  output  REGS  one-hot A read select (EX)
select_b_hi  output  REGS  one-hot B read select (EX)
shift_left  output  1  EX is RAMQU or RAMU (i[8:7]=11); enables ram3 and q3 drivers
shift_right  output  1  EX is RAMQD or RAMD (i[8:7]=10); enables ram0 and q0 drivers
y_sel_a  output  1  EX destination is RAMA (010); Y mux selects A
reg_wr  output  1  WB register-file write strobe
select_wr_hi  output  REGS  one-hot write select (WB); all zero when reg_wr=0
select_q_reg  output  2  WB Q control: 0 hold, 1 shift right, 2 load F, 3 shift left
flag_z  output  1  registered: f==0
flag_n  output  1  registered: f[WIDTH-1]
flag_c  output  1  registered: c[WIDTH-1]
flag_v  output  1  registered: c[WIDTH-1]^c[WIDTH-2]

Behaviour:
- Reset (async, rst_n=0): ex_valid=0, wb_valid=0, EX/WB opcode and address registers=0, reg_wr=0, select_wr_hi=0, select_q_reg=0, all flags=0, shift_left=shift_right=y_sel_a=0, select_a_hi=select_b_hi=one-hot entry 0. The block releases on the first rising edge after rst_n rises.
- Accept: when instr_valid & instr_ready, {i,a,b} load into EX and ex_valid=1 next cycle. Otherwise ex_valid=0 next cycle, i.e. a bubble.
- EX outputs decode from the EX registers and are gated by ex_valid. The opcode is sampled combinationally in the EX cycle.
- EX to WB advances every cycle with no backpressure: wb_valid<=ex_valid.
- Register write: wr = dest not in {000,001}.
- Q write encoding (per destination):
  - 100 → select_q_reg=1
  - 110 → select_q_reg=3
  - 000 → select_q_reg=2
  - all other destinations → 0
- WB outputs are registered from EX at the clock edge ending EX and are valid for exactly one cycle. reg_wr=wb_valid&wr.
- Flags: latched from f and c at the end of every EX cycle with ex_valid=1. They hold otherwise, including during bubbles.
- Q use: the source field reads Q when i[2:0] is in {000,010,110}.
- Hazard (no forwarding): instr_ready=0 when all of the following hold:
  - instr_valid=1 and ex_valid=1, and
  - either the EX instruction writes a register and (a==ex_b or b==ex_b),
  - or the EX instruction writes Q (select_q_reg≠0) and the incoming source uses Q.
  The stall lasts exactly 1 cycle: EX goes empty, and the instruction is accepted next cycle.
- instr_ready=1 in every other case, including after reset.
- Back-to-back independent instructions sustain 1 per cycle.
- A reset mid-operation drops the EX and WB contents. No write strobe fires on the reset cycle or the cycle after it.

Optional Feature:
Macro HAZARD_FWD_EN.
- Defined: instr_ready depends only on reset and is never deasserted by a hazard.
- Extra outputs fwd_a, fwd_b and fwd_q (1 bit each, EX-stage) are asserted when the EX operand matches the WB write (address equal with reg_wr=1, or Q written with the source using Q). The datapath then muxes in the WB value.
- Undefined: the ports are absent and the stall behaviour above applies.

Test Plan:
1. Reset: hold rst_n=0 with instr_valid=1 → reg_wr=0, select_q_reg=0, flags 0, select_a_hi=16'h0001, instr_ready=1.
2. Issue RAMF (i=9'o370) a=3 b=5 with f=4'h0 → cycle+1 select_a_hi=16'h0008 and select_b_hi=16'h0020; cycle+2 reg_wr=1, select_wr_hi=16'h0020, flag_z=1.
3. RAMF writing b=5, then next instruction a=5 → instr_ready=0 for 1 cycle, then accepted; with HAZARD_FWD_EN: no stall, fwd_a=1.
4. QREG (i[8:6]=000) then source AQ (i[2:0]=000) → 1-cycle stall; WB select_q_reg=2, reg_wr=0.
5. RAMQD then RAMQU, independent addresses → shift_right=1 then shift_left=1 on consecutive cycles; select_q_reg=1 then 3; no stall.
6. WIDTH=8, REGS=32, f=8'h80, c=8'h40 → flag_n=1, flag_v=1, flag_c=0; assert rst_n=0 during EX → no reg_wr pulse follows.
